// File: rtl/layernorm_hls_deadlock_token_ctrl_if.sv
// Signal bundle between the deadlock token controller and the per-process detect units.
// The master side is the controller; the slave side is the detect units and the report sink.
interface layernorm_hls_deadlock_token_ctrl_if #(
    parameter int unsigned PROC_NUM = 4
) ();
    logic [PROC_NUM-1:0] dl_detect_vec;
    logic [PROC_NUM-1:0] token_active_vec;
    logic                dl_detect_in_all;
    logic [PROC_NUM-1:0] origin_vec;
    logic                token_clear_all;
    logic                dl_report_valid;
    logic                dl_report_ready;
    logic [PROC_NUM-1:0] dl_report_origin;
    logic [PROC_NUM-1:0] dl_report_procs;
    logic                dl_timeout;
    logic                busy;

    modport master (
        input  dl_detect_vec, token_active_vec, dl_report_ready,
        output dl_detect_in_all, origin_vec, token_clear_all, dl_report_valid,
               dl_report_origin, dl_report_procs, dl_timeout, busy
    );

    modport slave (
        output dl_detect_vec, token_active_vec, dl_report_ready,
        input  dl_detect_in_all, origin_vec, token_clear_all, dl_report_valid,
               dl_report_origin, dl_report_procs, dl_timeout, busy
    );
endinterface

// File: rtl/layernorm_hls_deadlock_token_ctrl.sv
// Deadlock sequencer: round-robin origin grant, token-ring trace with timeout,
// valid/ready cycle report, token clear and re-arm. All outputs are registered.
module layernorm_hls_deadlock_token_ctrl #(
    parameter int unsigned PROC_NUM       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input logic clock,
    input logic reset,
    layernorm_hls_deadlock_token_ctrl_if.master bus
);
    localparam int unsigned IDX_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam logic [PROC_NUM-1:0] ONE = 1;

    typedef enum logic [2:0] {StIdle, StOrigin, StTrace, StReport, StClear} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    origin_id_q, origin_id_d;
    logic [PROC_NUM-1:0] procs_acc_q, procs_acc_d;
    logic [CNT_W-1:0]    counter_q, counter_d;

    logic                detect_in_all_q, detect_in_all_d;
    logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;
    logic                token_clear_q, token_clear_d;
    logic                rpt_valid_q, rpt_valid_d;
    logic [PROC_NUM-1:0] rpt_origin_q, rpt_origin_d;
    logic [PROC_NUM-1:0] rpt_procs_q, rpt_procs_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;

    // Round-robin pick: first set detect flag at or above rr_ptr, wrapping.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < PROC_NUM; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(PROC_NUM)) begin
                cand = cand - (IDX_W+1)'(PROC_NUM);
            end
            if (!sel_found && bus.dl_detect_vec[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        origin_id_d     = origin_id_q;
        procs_acc_d     = procs_acc_q;
        counter_d       = counter_q;
        detect_in_all_d = detect_in_all_q;
        origin_vec_d    = '0;
        token_clear_d   = 1'b0;
        rpt_valid_d     = rpt_valid_q;
        rpt_origin_d    = rpt_origin_q;
        rpt_procs_d     = rpt_procs_q;
        timeout_d       = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    origin_id_d     = sel_idx;
                    origin_vec_d    = ONE << sel_idx;
                    detect_in_all_d = 1'b1;
                    state_d         = StOrigin;
                end
            end
            StOrigin: begin
                procs_acc_d = ONE << origin_id_q;
                counter_d   = '0;
                state_d     = StTrace;
            end
            StTrace: begin
                procs_acc_d = procs_acc_q | bus.token_active_vec;
                counter_d   = counter_q + 1'b1;
                // The origin's own token in the first trace cycle is the launch, not a return.
                if (bus.token_active_vec[origin_id_q] && (counter_q != '0)) begin
                    rpt_valid_d  = 1'b1;
                    rpt_origin_d = ONE << origin_id_q;
                    rpt_procs_d  = procs_acc_d;
                    state_d      = StReport;
                end else if (counter_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d     = 1'b1;
                    token_clear_d = 1'b1;
                    state_d       = StClear;
                end
            end
            StReport: begin
                if (bus.dl_report_ready) begin
                    rpt_valid_d   = 1'b0;
                    rpt_origin_d  = '0;
                    rpt_procs_d   = '0;
                    token_clear_d = 1'b1;
                    state_d       = StClear;
                end
            end
            StClear: begin
                // token_clear_q marks the pulse cycle; tokens are only sampled after it.
                if (!token_clear_q && (bus.token_active_vec == '0)) begin
                    detect_in_all_d = 1'b0;
                    rr_ptr_d        = (origin_id_q == IDX_W'(PROC_NUM - 1)) ? '0
                                                                          : origin_id_q + 1'b1;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            origin_id_q     <= '0;
            procs_acc_q     <= '0;
            counter_q       <= '0;
            detect_in_all_q <= 1'b0;
            origin_vec_q    <= '0;
            token_clear_q   <= 1'b0;
            rpt_valid_q     <= 1'b0;
            rpt_origin_q    <= '0;
            rpt_procs_q     <= '0;
            timeout_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            origin_id_q     <= origin_id_d;
            procs_acc_q     <= procs_acc_d;
            counter_q       <= counter_d;
            detect_in_all_q <= detect_in_all_d;
            origin_vec_q    <= origin_vec_d;
            token_clear_q   <= token_clear_d;
            rpt_valid_q     <= rpt_valid_d;
            rpt_origin_q    <= rpt_origin_d;
            rpt_procs_q     <= rpt_procs_d;
            timeout_q       <= timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.dl_detect_in_all = detect_in_all_q;
    assign bus.origin_vec       = origin_vec_q;
    assign bus.token_clear_all  = token_clear_q;
    assign bus.dl_report_valid  = rpt_valid_q;
    assign bus.dl_report_origin = rpt_origin_q;
    assign bus.dl_report_procs  = rpt_procs_q;
    assign bus.dl_timeout       = timeout_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_layernorm_hls_deadlock_token_ctrl.sv
// Bench for the deadlock token controller: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a phase-level reference model.
module tb_layernorm_hls_deadlock_token_ctrl;
    localparam int P  = 4;
    localparam int TO = 8;

    logic clock;
    logic reset = 1'b0;
    bit   done  = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    layernorm_hls_deadlock_token_ctrl_if #(.PROC_NUM(P)) bus ();

    layernorm_hls_deadlock_token_ctrl #(
        .PROC_NUM      (P),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT event never seen within cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- reference model: phases of one detection round ----------------
    localparam int PH_IDLE = 0, PH_ORIGIN = 1, PH_TRACE = 2, PH_REPORT = 3, PH_CLEAR = 4;
    int m_ph, m_rr, m_origin, m_seen, m_trace_cycles, m_clear_cycles;
    bit m_timeout;

    task automatic model_reset();
        m_ph = PH_IDLE; m_rr = 0; m_origin = 0; m_seen = 0;
        m_trace_cycles = 0; m_clear_cycles = 0; m_timeout = 0;
    endtask

    task automatic model_step();
        int det, tav;
        det = int'(bus.dl_detect_vec);
        tav = int'(bus.token_active_vec);
        if (reset) begin
            model_reset();
            return;
        end
        case (m_ph)
            PH_IDLE: begin
                for (int k = P - 1; k >= 0; k--) begin
                    if (det[(m_rr + k) % P]) m_origin = (m_rr + k) % P;
                end
                if (det != 0) m_ph = PH_ORIGIN;
            end
            PH_ORIGIN: begin
                m_ph = PH_TRACE;
                m_seen = 1 << m_origin;
                m_trace_cycles = 0;
            end
            PH_TRACE: begin
                m_seen |= tav;
                m_trace_cycles++;
                if (tav[m_origin] && m_trace_cycles > 1) begin
                    m_ph = PH_REPORT;
                end else if (m_trace_cycles == TO) begin
                    m_timeout = 1;
                    m_ph = PH_CLEAR;
                    m_clear_cycles = 0;
                end
            end
            PH_REPORT: begin
                if (bus.dl_report_ready) begin
                    m_ph = PH_CLEAR;
                    m_clear_cycles = 0;
                end
            end
            default: begin
                m_clear_cycles++;
                if (m_clear_cycles > 1 && tav == 0) begin
                    m_ph = PH_IDLE;
                    m_rr = (m_origin + 1) % P;
                end
            end
        endcase
    endtask

    task automatic model_compare();
        bit rep;
        rep = (m_ph == PH_REPORT);
        chk("detect_in_all", 32'(bus.dl_detect_in_all), 32'(m_ph != PH_IDLE));
        chk("busy", 32'(bus.busy), 32'(m_ph != PH_IDLE));
        chk("origin_vec", 32'(bus.origin_vec), (m_ph == PH_ORIGIN) ? (1 << m_origin) : 0);
        chk("token_clear_all", 32'(bus.token_clear_all),
            32'(m_ph == PH_CLEAR && m_clear_cycles == 0));
        chk("report_valid", 32'(bus.dl_report_valid), 32'(rep));
        chk("report_origin", 32'(bus.dl_report_origin), rep ? (1 << m_origin) : 0);
        chk("report_procs", 32'(bus.dl_report_procs), rep ? m_seen : 0);
        chk("dl_timeout", 32'(bus.dl_timeout), 32'(m_timeout));
    endtask

    initial begin
        model_reset();
        while (!done) begin
            @(posedge clock);
            model_step();
            #1;
            if (!done) model_compare();
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_origin(input logic [3:0] exp, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.origin_vec != '0) begin
                seen = 1;
                chk(name, 32'(bus.origin_vec), 32'(exp));
            end
        end
        if (!seen) bound_expired(name);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (!bus.busy) seen = 1;
        end
        if (!seen) bound_expired(name);
    endtask

    initial begin
        bus.dl_detect_vec    = 4'b0100;
        bus.token_active_vec = '0;
        bus.dl_report_ready  = 1'b0;
        #1 reset = 1'b1;

        // Reset held with a pending detect flag: everything quiet.
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_detect_in_all", 32'(bus.dl_detect_in_all), 0);
        chk("rst_origin_vec", 32'(bus.origin_vec), 0);
        reset = 1'b0;
        tick();
        chk("release_origin", 32'(bus.origin_vec), 32'h4);
        bus.dl_detect_vec = '0;

        // Origin 2 never sees its token again: 8 trace cycles then abort.
        repeat (8) tick();
        chk("pre_timeout", 32'(bus.dl_timeout), 0);
        tick();
        chk("timeout_set", 32'(bus.dl_timeout), 1);
        chk("timeout_clear_pulse", 32'(bus.token_clear_all), 1);
        chk("timeout_no_report", 32'(bus.dl_report_valid), 0);
        wait_idle("idle_after_timeout");

        // rr_ptr is now 3; the only flag is bit 2. Reset mid-trace.
        bus.dl_detect_vec = 4'b0100;
        wait_origin(4'b0100, "origin_rr_wrap");
        bus.dl_detect_vec = '0;
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_detect_in_all", 32'(bus.dl_detect_in_all), 0);
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_timeout", 32'(bus.dl_timeout), 0);
        tick();
        reset = 1'b0;

        // 1010 with rr_ptr=0: origin 1, ring 1->2->3->1, slow report acceptance.
        bus.dl_detect_vec = 4'b1010;
        wait_origin(4'b0010, "origin_first");
        tick(); bus.token_active_vec = 4'b0010;
        tick(); bus.token_active_vec = 4'b0100;
        tick(); bus.token_active_vec = 4'b1000;
        tick(); bus.token_active_vec = 4'b0010;
        tick(); bus.token_active_vec = '0;
        for (int i = 0; i < 5; i++) begin
            chk("report_valid_held", 32'(bus.dl_report_valid), 1);
            chk("report_origin_lit", 32'(bus.dl_report_origin), 32'h2);
            chk("report_procs_lit", 32'(bus.dl_report_procs), 32'he);
            if (i < 4) tick();
        end
        bus.dl_report_ready = 1'b1;
        tick();
        chk("clear_after_handshake", 32'(bus.token_clear_all), 1);
        chk("report_dropped", 32'(bus.dl_report_valid), 0);
        bus.token_active_vec = 4'b0001;
        repeat (3) tick();
        chk("clear_wait_busy", 32'(bus.busy), 1);
        bus.token_active_vec = '0;
        tick();
        chk("clear_done_idle", 32'(bus.busy), 0);

        // Back-to-back rounds with 1010 still held.
        wait_origin(4'b1000, "origin_second");
        tick(); bus.token_active_vec = 4'b1000;
        tick(); bus.token_active_vec = 4'b1000;
        tick(); bus.token_active_vec = '0;
        wait_origin(4'b0010, "origin_third");
        bus.dl_detect_vec = '0;
        tick(); bus.token_active_vec = 4'b0010;
        tick(); bus.token_active_vec = 4'b0110;
        tick(); bus.token_active_vec = '0;
        wait_idle("idle_after_third");

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            bus.dl_detect_vec    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            bus.token_active_vec = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 9) == 0) bus.token_active_vec = '0;
            bus.dl_report_ready  = 1'($urandom);
        end

        tick();
        done = 1'b1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
